// File: rtl/ysyx_22050598_icache_pkg.sv
// Shared constants, FSM encoding and line word-select helper for the instruction cache.
package ysyx_22050598_icache_pkg;

  localparam int unsigned LINE_B = 16;
  localparam int unsigned OFF_W  = $clog2(LINE_B);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLookup = 2'b01,
    StRefill = 2'b10,
    StResp   = 2'b11
  } icache_state_e;

  // Bytes 0-3 of the line live in bits [31:0].
  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ysyx_22050598_icache_array.sv
// Tag/valid/data storage: combinational read, synchronous write, flash-clear of valid bits.
module ysyx_22050598_icache_array #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 64 - IDX_W - 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [127:0]       rd_data,
  input  logic               wr_en,
  input  logic               wr_set_valid,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [127:0]       wr_data,
  input  logic               flush
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [127:0]     data_mem [SETS];

  // Flush has priority so a fence on the refill-write cycle leaves the line invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx]  <= wr_tag;
      data_mem[idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

endmodule

// File: rtl/ysyx_22050598_icache.sv
// Direct-mapped read-only instruction cache with single-line refill on miss.
// Optional hit/miss counters enabled by defining YSYX_22050598_ICACHE_PERF_EN.
module ysyx_22050598_icache
  import ysyx_22050598_icache_pkg::*;
#(
  parameter int unsigned SETS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ifu_req_valid,
  output logic         ifu_req_ready,
  input  logic [63:0]  ifu_req_addr,
  output logic         ifu_resp_valid,
  output logic [31:0]  ifu_resp_inst,
  input  logic         fence_i,
  output logic [63:0]  mem_addr,
  output logic         mem_valid,
  input  logic [127:0] mem_data,
`ifdef YSYX_22050598_ICACHE_PERF_EN
  output logic [63:0]  perf_hit,
  output logic [63:0]  perf_miss,
`endif
  input  logic         mem_ready
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 64 - IDX_W - OFF_W;

  icache_state_e state_q, state_d;
  logic [63:2]      addr_q;
  logic [31:0]      word_q;
  logic             fence_pend_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [127:0]     rd_data;
  logic             hit;
  logic             wr_en;
  logic             wr_set_valid;

  assign idx = addr_q[IDX_W+3:4];
  assign tag = addr_q[63:IDX_W+4];
  // A fence in the lookup cycle forces a miss.
  assign hit = rd_valid && (rd_tag == tag) && !fence_i;

  ysyx_22050598_icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .idx          (idx),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_set_valid (wr_set_valid),
    .wr_tag       (tag),
    .wr_data      (mem_data),
    .flush        (fence_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ifu_req_valid) state_d = StLookup;
      StLookup: state_d = hit ? StIdle : StRefill;
      StRefill: if (mem_ready) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_inst  = 32'h0;
    mem_valid      = 1'b0;
    mem_addr       = 64'h0;
    wr_en          = 1'b0;
    wr_set_valid   = 1'b0;
    unique case (state_q)
      StIdle: ifu_req_ready = 1'b1;
      StLookup: begin
        if (hit) begin
          ifu_resp_valid = 1'b1;
          ifu_resp_inst  = line_word(rd_data, addr_q[3:2]);
        end else begin
          mem_valid = 1'b1;
          mem_addr  = {addr_q[63:4], 4'b0};
        end
      end
      StRefill: begin
        mem_valid    = 1'b1;
        mem_addr     = {addr_q[63:4], 4'b0};
        wr_en        = mem_ready;
        wr_set_valid = !fence_i && !fence_pend_q;
      end
      StResp: begin
        ifu_resp_valid = 1'b1;
        ifu_resp_inst  = word_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      word_q       <= '0;
      fence_pend_q <= 1'b0;
    end else begin
      if (state_q == StIdle && ifu_req_valid) addr_q <= ifu_req_addr[63:2];
      if (wr_en) word_q <= line_word(mem_data, addr_q[3:2]);
      // Remember a fence seen while waiting so the returned line is not marked valid.
      if (state_q == StRefill) fence_pend_q <= fence_pend_q | fence_i;
      else                     fence_pend_q <= 1'b0;
    end
  end

`ifdef YSYX_22050598_ICACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else if (state_q == StLookup) begin
      if (hit) perf_hit  <= perf_hit + 64'd1;
      else     perf_miss <= perf_miss + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050598_icache.sv
// Self-checking bench: directed scenarios plus randomized fetches against a line-level model.
module tb_ysyx_22050598_icache;

  logic         clk = 1'b0;
  logic         rst;
  logic         ifu_req_valid;
  logic         ifu_req_ready;
  logic [63:0]  ifu_req_addr;
  logic         ifu_resp_valid;
  logic [31:0]  ifu_resp_inst;
  logic         fence_i;
  logic [63:0]  mem_addr;
  logic         mem_valid;
  logic [127:0] mem_data;
  logic         mem_ready;
`ifdef YSYX_22050598_ICACHE_PERF_EN
  logic [63:0]  perf_hit;
  logic [63:0]  perf_miss;
`endif

  int cmps = 0;
  int errs = 0;

  // Reference model: whole lines per set.
  bit           m_valid [64];
  logic [53:0]  m_tag   [64];
  logic [127:0] m_line  [64];

  always #5 clk = ~clk;

  ysyx_22050598_icache dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_inst  (ifu_resp_inst),
    .fence_i        (fence_i),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data),
`ifdef YSYX_22050598_ICACHE_PERF_EN
    .perf_hit       (perf_hit),
    .perf_miss      (perf_miss),
`endif
    .mem_ready      (mem_ready)
  );

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [63:0] a);
    logic [127:0] sh;
    sh = line >> (32 * int'(a[3:2]));
    return sh[31:0];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  // fmode: 0 none, 1 fence while waiting in refill, 2 fence on the mem_ready cycle.
  function automatic void model_fetch(input logic [63:0] a, input logic [127:0] line,
                                      input int fmode, output bit miss, output logic [31:0] w);
    int unsigned i;
    i = int'(a[9:4]);
    miss = !(m_valid[i] && m_tag[i] == a[63:10]);
    if (miss) begin
      m_line[i] = line;
      m_tag[i]  = a[63:10];
      if (fmode != 0) model_clear();
      else            m_valid[i] = 1'b1;
    end
    w = word_of(m_line[i], a);
  endfunction

  task automatic pulse_fence();
    @(negedge clk); fence_i = 1'b1;
    @(negedge clk); fence_i = 1'b0;
    model_clear();
  endtask

  task automatic fetch(input logic [63:0] a, input int delay, input logic [127:0] line,
                       input int fmode, output bit got, output logic [31:0] inst,
                       output bit missed, output logic [63:0] maddr, output int lat,
                       output bit mv_resp, output bit pulse_ok);
    int cnt;
    got = 0; inst = '0; missed = 0; maddr = '0; lat = 0; mv_resp = 0; pulse_ok = 0; cnt = 0;
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = a;
    @(posedge clk);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    for (int i = 1; i < 40 && !got; i++) begin
      if (i > 1) begin @(posedge clk); @(negedge clk); end
      mem_ready = 1'b0;
      fence_i   = 1'b0;
      if (ifu_resp_valid) begin
        got = 1; inst = ifu_resp_inst; lat = i; mv_resp = mem_valid;
      end else if (mem_valid) begin
        if (!missed) begin missed = 1; maddr = mem_addr; cnt = 0; end
        else cnt++;
        if (cnt == delay) begin
          mem_ready = 1'b1;
          mem_data  = line;
          if (fmode == 2 || (fmode == 1 && delay == 1)) fence_i = 1'b1;
        end else if (fmode == 1 && cnt == delay - 1 && cnt >= 1) begin
          fence_i = 1'b1;
        end
      end
    end
    mem_ready = 1'b0;
    fence_i   = 1'b0;
    if (got) begin
      @(posedge clk); @(negedge clk);
      pulse_ok = !ifu_resp_valid;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    cmps += 5;
    if (ifu_req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", ifu_req_ready); end
    if (ifu_resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got %b want 0", ifu_resp_valid); end
    if (mem_valid !== 1'b0) begin errs++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    if (mem_addr !== 64'h0) begin errs++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    if (ifu_resp_inst !== 32'h0) begin errs++; $display("FAIL reset_inst got %h want 0", ifu_resp_inst); end
  endtask

  task automatic test_cold_miss();
    bit got, missed, mv, pok, em; logic [31:0] inst, ew; logic [63:0] ma; int lat;
    logic [127:0] line;
    line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    model_fetch(64'h8000_0004, line, 0, em, ew);
    fetch(64'h8000_0004, 5, line, 0, got, inst, missed, ma, lat, mv, pok);
    cmps += 6;
    if (!got) begin errs++; $display("FAIL cold_resp got timeout want response"); end
    if (missed !== 1'b1) begin errs++; $display("FAIL cold_miss got %b want 1", missed); end
    if (ma !== 64'h8000_0000) begin errs++; $display("FAIL cold_mem_addr got %h want 80000000", ma); end
    if (inst !== 32'hBBBBBBBB) begin errs++; $display("FAIL cold_inst got %h want bbbbbbbb", inst); end
    if (mv !== 1'b0) begin errs++; $display("FAIL cold_mv_in_resp got %b want 0", mv); end
    if (pok !== 1'b1) begin errs++; $display("FAIL cold_pulse got %b want 1", pok); end
  endtask

  task automatic test_hit();
    bit got, missed, mv, pok, em; logic [31:0] inst, ew; logic [63:0] ma; int lat;
    model_fetch(64'h8000_000C, '0, 0, em, ew);
    fetch(64'h8000_000C, 1, '0, 0, got, inst, missed, ma, lat, mv, pok);
    cmps += 4;
    if (missed !== 1'b0) begin errs++; $display("FAIL hit_no_mem got %b want 0", missed); end
    if (lat !== 1) begin errs++; $display("FAIL hit_latency got %0d want 1", lat); end
    if (inst !== 32'hDDDDDDDD) begin errs++; $display("FAIL hit_inst got %h want dddddddd", inst); end
    if (pok !== 1'b1) begin errs++; $display("FAIL hit_pulse got %b want 1", pok); end
  endtask

`ifdef YSYX_22050598_ICACHE_PERF_EN
  task automatic test_perf();
    cmps += 2;
    if (perf_hit !== 64'd1) begin errs++; $display("FAIL perf_hit got %0d want 1", perf_hit); end
    if (perf_miss !== 64'd1) begin errs++; $display("FAIL perf_miss got %0d want 1", perf_miss); end
  endtask
`endif

  task automatic test_conflict();
    bit got, missed, mv, pok, em; logic [31:0] inst, ew; logic [63:0] ma; int lat;
    logic [127:0] line;
    line = {$urandom, $urandom, $urandom, $urandom};
    model_fetch(64'h8000_0400, line, 0, em, ew);
    fetch(64'h8000_0400, 2, line, 0, got, inst, missed, ma, lat, mv, pok);
    cmps += 3;
    if (missed !== 1'b1) begin errs++; $display("FAIL conflict_miss got %b want 1", missed); end
    if (ma !== 64'h8000_0400) begin errs++; $display("FAIL conflict_addr got %h want 80000400", ma); end
    if (inst !== ew) begin errs++; $display("FAIL conflict_inst got %h want %h", inst, ew); end
    line = {$urandom, $urandom, $urandom, $urandom};
    model_fetch(64'h8000_0000, line, 0, em, ew);
    fetch(64'h8000_0000, 3, line, 0, got, inst, missed, ma, lat, mv, pok);
    cmps += 2;
    if (missed !== 1'b1) begin errs++; $display("FAIL conflict_remiss got %b want 1", missed); end
    if (inst !== ew) begin errs++; $display("FAIL conflict_reinst got %h want %h", inst, ew); end
  endtask

  task automatic test_fence();
    bit got, missed, mv, pok, em; logic [31:0] inst, ew; logic [63:0] ma; int lat;
    logic [127:0] line;
    pulse_fence();
    for (int m = 0; m < 3; m++) begin
      line = {$urandom, $urandom, $urandom, $urandom};
      model_fetch(64'h8000_0008, line, m, em, ew);
      fetch(64'h8000_0008, 3, line, m, got, inst, missed, ma, lat, mv, pok);
      cmps += 2;
      if (missed !== 1'b1) begin errs++; $display("FAIL fence_miss mode %0d got %b want 1", m, missed); end
      if (inst !== ew) begin errs++; $display("FAIL fence_inst mode %0d got %h want %h", m, inst, ew); end
      if (m == 0) pulse_fence();
    end
    model_fetch(64'h8000_0008, 128'h0, 0, em, ew);
    fetch(64'h8000_0008, 2, 128'h0, 0, got, inst, missed, ma, lat, mv, pok);
    cmps++;
    if (missed !== 1'b1) begin errs++; $display("FAIL fence_after_refill got %b want 1", missed); end
  endtask

  task automatic test_reset_mid_refill();
    bit got, missed, mv, pok, em, saw; logic [31:0] inst, ew; logic [63:0] ma; int lat;
    bit seen;
    seen = 0;
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 64'h8000_1230;
    @(posedge clk);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_valid) seen = 1;
      else begin @(posedge clk); @(negedge clk); end
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    cmps += 4;
    if (!seen) begin errs++; $display("FAIL rstmid_mem_valid_seen got 0 want 1"); end
    if (mem_valid !== 1'b0) begin errs++; $display("FAIL rstmid_mem_valid got %b want 0", mem_valid); end
    if (ifu_resp_valid !== 1'b0) begin errs++; $display("FAIL rstmid_resp got %b want 0", ifu_resp_valid); end
    if (ifu_req_ready !== 1'b1) begin errs++; $display("FAIL rstmid_idle got %b want 1", ifu_req_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    mem_ready = 1'b1;
    mem_data  = {4{32'h5A5A_1234}};
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (ifu_resp_valid || mem_valid) saw = 1;
    end
    cmps++;
    if (saw !== 1'b0) begin errs++; $display("FAIL rstmid_late_ready got activity want none"); end
    model_fetch(64'h8000_1230, {4{32'h0BAD_F00D}}, 0, em, ew);
    fetch(64'h8000_1230, 2, {4{32'h0BAD_F00D}}, 0, got, inst, missed, ma, lat, mv, pok);
    cmps += 2;
    if (missed !== 1'b1) begin errs++; $display("FAIL rstmid_no_write got %b want 1", missed); end
    if (inst !== ew) begin errs++; $display("FAIL rstmid_inst got %h want %h", inst, ew); end
  endtask

  task automatic test_random();
    bit got, missed, mv, pok, em; logic [31:0] inst, ew; logic [63:0] a, ma; int lat, fm, d;
    logic [127:0] line;
    for (int n = 0; n < 150; n++) begin
      a = 64'h8000_0000 + (64'($urandom_range(0, 3)) << 10) + (64'($urandom_range(0, 3)) << 4)
          + (64'($urandom_range(0, 3)) << 2);
      line = {$urandom, $urandom, $urandom, $urandom};
      d    = int'($urandom_range(1, 4));
      fm   = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 19) == 0) pulse_fence();
      model_fetch(a, line, fm, em, ew);
      fetch(a, d, line, fm, got, inst, missed, ma, lat, mv, pok);
      cmps += 3;
      if (!got) begin errs++; $display("FAIL rand_resp #%0d got timeout want response", n); end
      if (missed !== em) begin errs++; $display("FAIL rand_miss #%0d addr %h got %b want %b", n, a, missed, em); end
      if (inst !== ew) begin errs++; $display("FAIL rand_inst #%0d addr %h got %h want %h", n, a, inst, ew); end
      if (em) begin
        cmps++;
        if (ma !== {a[63:4], 4'b0}) begin errs++; $display("FAIL rand_addr #%0d got %h want %h", n, ma, {a[63:4], 4'b0}); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    fence_i       = 1'b0;
    mem_data      = '0;
    mem_ready     = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
`ifdef YSYX_22050598_ICACHE_PERF_EN
    test_perf();
`endif
    test_conflict();
    test_fence();
    test_reset_mid_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
